// File: rtl/fifo_frame_pkg.sv
// Shared constants, state encoding and helpers for the FIFO frame serializer.
package fifo_frame_pkg;

    localparam logic [7:0] FRAME_HEADER = 8'hBC;
    localparam logic [7:0] IDLE_BYTE    = 8'h00;

    typedef enum logic [3:0] {
        S_IDLE = 4'b0001,
        S_LOAD = 4'b0010,
        S_SEND = 4'b0100,
        S_PAD  = 4'b1000
    } state_t;

    // States in which a frame byte (payload or pad) is on the line.
    function automatic logic is_frame_state(input state_t s);
        return (s == S_SEND) || (s == S_PAD);
    endfunction

endpackage

// File: rtl/fifo_frame_serializer_shifter.sv
// Holds the bytes of the current FIFO word not yet emitted, MSB-aligned, and tracks
// which lane of that word is currently on the output.
module word_byte_shifter (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        shift,
    input  logic [31:0] word,
    output logic [1:0]  lane,
    output logic [7:0]  next_byte
);

    logic [31:0] word_q;

    // Byte 0 leaves on the load edge itself, so only bytes 1..3 are kept.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            word_q <= '0;
            lane   <= 2'd0;
        end else if (load) begin
            word_q <= {word[23:0], 8'h00};
            lane   <= 2'd0;
        end else if (shift) begin
            word_q <= {word_q[23:0], 8'h00};
            lane   <= lane + 2'd1;
        end
    end

    assign next_byte = word_q[31:24];

endmodule

// File: rtl/fifo_frame_serializer.sv
// Pops 36-bit FWFT FIFO words and emits fixed-length byte frames, MSB byte first.
// Optional FIFO_FRAME_SER_HDR_INSERT_EN forces byte 0 of every frame to FRAME_HEADER.
//
//   state  | meaning
//   S_IDLE | no burst; waiting for start
//   S_LOAD | burst active, waiting for the first word of a frame
//   S_SEND | shifting word bytes onto fd_out
//   S_PAD  | FIFO ran dry mid-frame; idle bytes keep the frame length intact
module fifo_frame_serializer
    import fifo_frame_pkg::*;
#(
    parameter int FIFO_WIDTH   = 36,
    parameter int FRAME_WIDTH  = 48,
    parameter int NFRAME_WIDTH = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    stop,
    input  logic [NFRAME_WIDTH-1:0] nframes,
    input  logic                    fifo_empty,
    input  logic [FIFO_WIDTH-1:0]   fifo_dout,
    output logic                    fifo_rd_en,
    output logic [7:0]              fd_out,
    output logic                    fd_valid,
    output logic                    busy,
    output logic                    frame_done,
    output logic                    underrun
);

    localparam int                 CNT_W     = $clog2(FRAME_WIDTH);
    localparam logic [CNT_W-1:0]   LAST_BYTE = CNT_W'(FRAME_WIDTH - 1);

    state_t                  state, state_nxt;
    logic [CNT_W-1:0]        byte_cnt;
    logic [NFRAME_WIDTH-1:0] frames_left;
    logic                    stop_seen;
    logic [1:0]              lane;
    logic [7:0]              next_byte, head_byte, fd_out_nxt;
    logic                    start_ok, in_frame, frame_last, end_burst;
    logic                    frame_pop, mid_pop, starve;
    logic                    unused_bits;

    assign unused_bits = ^fifo_dout[FIFO_WIDTH-1:32];

`ifdef FIFO_FRAME_SER_HDR_INSERT_EN
    assign head_byte = FRAME_HEADER;
`else
    assign head_byte = fifo_dout[31:24];
`endif

    assign start_ok   = (state == S_IDLE) && start && (nframes != '0);
    assign in_frame   = is_frame_state(state);
    assign frame_last = in_frame && (byte_cnt == LAST_BYTE);
    // A stop arriving on the last byte still counts as seen during this frame.
    assign end_burst  = frame_last &&
                        ((frames_left <= NFRAME_WIDTH'(1)) || stop_seen || stop);
    assign frame_pop  = !fifo_empty &&
                        (((state == S_LOAD) && !stop) || (frame_last && !end_burst));
    assign mid_pop    = !fifo_empty && (state == S_SEND) && (lane == 2'd3) && !frame_last;
    assign starve     = fifo_empty && (state == S_SEND) && (lane == 2'd3) && !frame_last;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: if (start_ok) state_nxt = S_LOAD;
            S_LOAD: begin
                if (stop)           state_nxt = S_IDLE;
                else if (frame_pop) state_nxt = S_SEND;
            end
            S_SEND, S_PAD: begin
                if (frame_last) begin
                    if (end_burst)      state_nxt = S_IDLE;
                    else if (frame_pop) state_nxt = S_SEND;
                    else                state_nxt = S_LOAD;
                end else if (starve) begin
                    state_nxt = S_PAD;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        fifo_rd_en = frame_pop || mid_pop;
        fd_out_nxt = IDLE_BYTE;
        if (frame_pop)
            fd_out_nxt = head_byte;
        else if (mid_pop)
            fd_out_nxt = fifo_dout[31:24];
        else if ((state == S_SEND) && (state_nxt == S_SEND))
            fd_out_nxt = next_byte;
    end

    word_byte_shifter u_shifter (
        .clk       (clk),
        .rst       (rst),
        .load      (fifo_rd_en),
        .shift     ((state == S_SEND) && !fifo_rd_en),
        .word      (fifo_dout[31:0]),
        .lane      (lane),
        .next_byte (next_byte)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            byte_cnt    <= '0;
            frames_left <= '0;
            stop_seen   <= 1'b0;
            fd_out      <= IDLE_BYTE;
            fd_valid    <= 1'b0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            fd_out     <= fd_out_nxt;
            fd_valid   <= is_frame_state(state_nxt);
            busy       <= (state_nxt != S_IDLE);
            frame_done <= frame_last;

            if (frame_pop)
                byte_cnt <= '0;
            else if (in_frame && !frame_last)
                byte_cnt <= byte_cnt + CNT_W'(1);
            else
                byte_cnt <= '0;

            if (start_ok)
                frames_left <= nframes;
            else if (frame_last && (frames_left != '0))
                frames_left <= frames_left - NFRAME_WIDTH'(1);

            if (state == S_IDLE)
                stop_seen <= 1'b0;
            else if (in_frame && stop)
                stop_seen <= 1'b1;

            if (start_ok)
                underrun <= 1'b0;
            else if (starve)
                underrun <= 1'b1;
        end
    end

endmodule
